// File: rtl/inst_inject_checker.sv
// inst_inject_checker: queues {instruction, expected PC} pairs, feeds them to
// the Decoder one per clock in place of InstMemory output, and checks the
// processor's PC against the expected value for each issued entry.
module inst_inject_checker #(
    parameter int                    DBITS          = 32,
    parameter int                    INST_BIT_WIDTH = 32,
    parameter int                    DEPTH          = 16,
    parameter int                    PTR_BITS       = 4,
    parameter int                    CNT_BITS       = 16,
    parameter logic [INST_BIT_WIDTH-1:0] NOP_INST   = 32'h80000000,
    parameter int                    HALT_ON_ERR    = 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      inVld,
    output logic                      inRdy,
    input  logic [INST_BIT_WIDTH-1:0] inInst,
    input  logic [DBITS-1:0]          inExpPc,
    input  logic                      inChk,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      flush,
    input  logic [DBITS-1:0]          pcOut,
    input  logic [INST_BIT_WIDTH-1:0] instWordReal,
    output logic [INST_BIT_WIDTH-1:0] instWord,
    output logic                      injecting,
    output logic                      halted,
    output logic [CNT_BITS-1:0]       stepCnt,
    output logic [CNT_BITS-1:0]       errCnt,
    output logic [CNT_BITS-1:0]       stallCnt,
    output logic [DBITS-1:0]          firstErrPc,
    output logic [CNT_BITS-1:0]       firstErrIdx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam logic [PTR_BITS:0]   FULL_CNT = (PTR_BITS+1)'(DEPTH);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    state_t state;

    logic [INST_BIT_WIDTH-1:0] fifo_inst [0:DEPTH-1];
    logic [DBITS-1:0]          fifo_pc   [0:DEPTH-1];
    logic                      fifo_chk  [0:DEPTH-1];

    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                err_seen;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic mismatch;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign inRdy    = !full && !flush;
    assign push     = inVld && inRdy;
    // stop and flush both pre-empt the head: it is neither consumed nor checked
    assign pop      = (state == S_RUN) && !stop && !flush && !empty;
    assign mismatch = pop && fifo_chk[rd_ptr] && (pcOut != fifo_pc[rd_ptr]);

    // Entry storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= inInst;
            fifo_pc[wr_ptr]   <= inExpPc;
            fifo_chk[wr_ptr]  <= inChk;
        end
    end

    // Pointers and occupancy; flush empties the queue and drops any push
    always_ff @(posedge clk) begin
        if (!resetN || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_BITS+1)'(1);
                2'b01:   count <= count - (PTR_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Control FSM with registered injecting/halted flags
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= S_IDLE;
            injecting <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state     <= S_RUN;
                        injecting <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        injecting <= 1'b0;
                    end else if (mismatch && (HALT_ON_ERR != 0)) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (stop) begin
                        state     <= S_IDLE;
                        injecting <= 1'b0;
                        halted    <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    injecting <= 1'b0;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    // Step, error and stall counters plus first-error capture
    always_ff @(posedge clk) begin
        if (!resetN) begin
            stepCnt     <= '0;
            errCnt      <= '0;
            stallCnt    <= '0;
            firstErrPc  <= '0;
            firstErrIdx <= '0;
            err_seen    <= 1'b0;
        end else begin
            if (pop) stepCnt <= stepCnt + CNT_BITS'(1);
            if (state == S_RUN && empty && stallCnt != CNT_MAX)
                stallCnt <= stallCnt + CNT_BITS'(1);
            if (mismatch) begin
                if (errCnt != CNT_MAX) errCnt <= errCnt + CNT_BITS'(1);
                if (!err_seen) begin
                    firstErrPc  <= pcOut;
                    firstErrIdx <= stepCnt;
                    err_seen    <= 1'b1;
                end
            end
        end
    end

    // Decoder instruction mux: pass-through when idle, NOP when starved/halted
    always_comb begin
        instWord = instWordReal;
        case (state)
            S_RUN:   instWord = empty ? NOP_INST : fifo_inst[rd_ptr];
            S_HALT:  instWord = NOP_INST;
            default: instWord = instWordReal;
        endcase
    end

endmodule

// File: tb/tb_inst_inject_checker.sv
// Directed bench for inst_inject_checker. Two instances share all inputs:
// dut halts on error, dut_nh keeps running; each test resets both.
module tb_inst_inject_checker;

    localparam logic [31:0] NOP = 32'h80000000;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        inVld = 1'b0;
    logic [31:0] inInst = '0;
    logic [31:0] inExpPc = '0;
    logic        inChk = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pcOut = '0;
    logic [31:0] instWordReal = 32'h12345678;

    logic        inRdy, injecting, halted;
    logic [31:0] instWord, firstErrPc;
    logic [15:0] stepCnt, errCnt, stallCnt, firstErrIdx;

    logic        inRdy_nh, injecting_nh, halted_nh;
    logic [31:0] instWord_nh, firstErrPc_nh;
    logic [15:0] stepCnt_nh, errCnt_nh, stallCnt_nh, firstErrIdx_nh;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_inject_checker #(.HALT_ON_ERR(1)) dut (
        .clk(clk), .resetN(resetN), .inVld(inVld), .inRdy(inRdy),
        .inInst(inInst), .inExpPc(inExpPc), .inChk(inChk),
        .start(start), .stop(stop), .flush(flush), .pcOut(pcOut),
        .instWordReal(instWordReal), .instWord(instWord),
        .injecting(injecting), .halted(halted), .stepCnt(stepCnt),
        .errCnt(errCnt), .stallCnt(stallCnt), .firstErrPc(firstErrPc),
        .firstErrIdx(firstErrIdx)
    );

    inst_inject_checker #(.HALT_ON_ERR(0)) dut_nh (
        .clk(clk), .resetN(resetN), .inVld(inVld), .inRdy(inRdy_nh),
        .inInst(inInst), .inExpPc(inExpPc), .inChk(inChk),
        .start(start), .stop(stop), .flush(flush), .pcOut(pcOut),
        .instWordReal(instWordReal), .instWord(instWord_nh),
        .injecting(injecting_nh), .halted(halted_nh), .stepCnt(stepCnt_nh),
        .errCnt(errCnt_nh), .stallCnt(stallCnt_nh), .firstErrPc(firstErrPc_nh),
        .firstErrIdx(firstErrIdx_nh)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        step();
        resetN = 1'b1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic c);
        inVld = 1'b1; inInst = inst; inExpPc = pc; inChk = c;
        step();
        inVld = 1'b0;
    endtask

    logic [31:0] t1_inst [4] = '{32'h80660001, 32'h50c60008, 32'h805d0278, 32'hb04d009f};
    logic [31:0] t1_pc   [4] = '{32'h264, 32'h268, 32'h26c, 32'h270};

    initial begin
        // reset state
        do_reset();
        chk("rst_inRdy", inRdy, 1);
        chk("rst_injecting", injecting, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instWord", instWord, 32'h12345678);
        chk("rst_stepCnt", stepCnt, 0);
        chk("rst_errCnt", errCnt, 0);
        chk("rst_stallCnt", stallCnt, 0);

        // basic 4-entry stream with matching PCs
        for (int i = 0; i < 4; i++) push(t1_inst[i], t1_pc[i], 1'b1);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pcOut = t1_pc[i];
            #1;
            chk($sformatf("t1_inst%0d", i), instWord, t1_inst[i]);
            chk($sformatf("t1_inj%0d", i), injecting, 1);
            step();
        end
        chk("t1_stepCnt", stepCnt, 4);
        chk("t1_errCnt", errCnt, 0);
        chk("t1_stall0", stallCnt, 0);
        chk("t1_nop", instWord, NOP);
        step();
        chk("t1_stall1", stallCnt, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t1_idle_inj", injecting, 0);
        chk("t1_idle_word", instWord, 32'h12345678);

        // fill to DEPTH, blocked 17th push, start with simultaneous push
        do_reset();
        for (int i = 0; i < 16; i++) push(32'h1000 + i, 32'(i * 4), 1'b0);
        chk("t2_full_rdy", inRdy, 0);
        push(32'hdeadbeef, 32'h0, 1'b0);
        chk("t2_full_rdy17", inRdy, 0);
        inVld = 1'b1; inInst = 32'hcafef00d; start = 1'b1;
        step();
        inVld = 1'b0; start = 1'b0;
        chk("t2_still_full", inRdy, 0);
        chk("t2_head", instWord, 32'h1000);
        step();
        chk("t2_pop_rdy", inRdy, 1);
        chk("t2_step1", stepCnt, 1);
        chk("t2_head1", instWord, 32'h1001);
        for (int i = 0; i < 14; i++) step();
        chk("t2_last", instWord, 32'h100f);
        step();
        chk("t2_step16", stepCnt, 16);
        chk("t2_empty_nop", instWord, NOP);
        stop = 1'b1; step(); stop = 1'b0;

        // halt on mismatch at entry index 2
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h2000 + i, 32'h270 + 32'(i * 4), 1'b1);
        start = 1'b1; step(); start = 1'b0;
        pcOut = 32'h270; step();
        pcOut = 32'h274; step();
        pcOut = 32'h27c; step();
        chk("t3_errCnt", errCnt, 1);
        chk("t3_firstPc", firstErrPc, 32'h27c);
        chk("t3_firstIdx", firstErrIdx, 2);
        chk("t3_halted", halted, 1);
        chk("t3_step", stepCnt, 3);
        chk("t3_nop", instWord, NOP);
        step();
        chk("t3_nopop", stepCnt, 3);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t3_unhalt", halted, 0);
        chk("t3_idle_inj", injecting, 0);
        chk("t3_idle_word", instWord, 32'h12345678);

        // no-halt instance: mismatches at steps 1 and 5
        do_reset();
        for (int i = 0; i < 7; i++) push(32'h3000 + i, 32'h100 + 32'(i * 4), 1'b1);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pcOut = 32'h100 + 32'(i * 4) + ((i == 1 || i == 5) ? 32'h40 : 32'h0);
            step();
            if (i == 1) begin
                chk("t4_err_mid", errCnt_nh, 1);
                chk("t4_nohalt", halted_nh, 0);
            end
        end
        chk("t4_errCnt", errCnt_nh, 2);
        chk("t4_firstIdx", firstErrIdx_nh, 1);
        chk("t4_firstPc", firstErrPc_nh, 32'h144);
        chk("t4_step", stepCnt_nh, 7);
        chk("t4_inj", injecting_nh, 1);
        stop = 1'b1; step(); stop = 1'b0;

        // unchecked entry with wrong expected PC
        do_reset();
        push(32'h4000, 32'h500, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        pcOut = 32'h999; step();
        chk("t5_errCnt", errCnt, 0);
        chk("t5_step", stepCnt, 1);
        chk("t5_halted", halted, 0);
        stop = 1'b1; step(); stop = 1'b0;

        // reset mid-run with entries queued
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h5000 + i, 32'h0, 1'b0);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("t6_pre_step", stepCnt, 1);
        resetN = 1'b0; step(); resetN = 1'b1;
        chk("t6_inj", injecting, 0);
        chk("t6_step", stepCnt, 0);
        chk("t6_rdy", inRdy, 1);
        chk("t6_stall", stallCnt, 0);
        chk("t6_word", instWord, 32'h12345678);

        // flush with a concurrent push
        push(32'h6000, 32'h0, 1'b0);
        push(32'h6001, 32'h0, 1'b0);
        flush = 1'b1; inVld = 1'b1; inInst = 32'h6002;
        #1;
        chk("t6_flush_rdy", inRdy, 0);
        step();
        flush = 1'b0; inVld = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("t6_flush_nop", instWord, NOP);
        step();
        chk("t6_flush_stall", stallCnt, 1);
        chk("t6_flush_step", stepCnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
